issue_queue_decoder: RTL and testbench

Parametrised successor to the single-slot decode stage. It buffers fetched instructions in a `2**IQ_DEPTH_BIT`-entry FIFO and decodes the head entry. It dispatches one instruction per cycle to ROB, RS or LSB as a registered bundle. It also handles JAL/JALR redirection and the ROB mispredict flush. It sits between the instruction fetcher and the ROB/RS/LSB, and reads operands from the register file.

---
 rtl/issue_queue_decoder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_issue_queue_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_decoder.sv
// Instruction queue plus head decoder: buffers fetched words, decodes the oldest
// entry and dispatches one registered bundle per cycle to the ROB, RS or LSB.
package issue_queue_decoder_pkg;
    typedef enum logic [1:0] {
        TypeRd = 2'd0,
        TypeSt = 2'd1,
        TypeBr = 2'd2
    } rob_type_t;
endpackage

module issue_queue_decoder
    import issue_queue_decoder_pkg::*;
#(
    parameter int IQ_DEPTH_BIT  = 2,
    parameter int ROB_WIDTH_BIT = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     ins_valid,
    input  logic [31:0]              ins,
    input  logic [31:0]              pc,
    input  logic                     pred_jump,
    output logic                     iq_full,
    output logic                     IFetcher_clear,
    output logic [31:0]              IFetcher_new_addr,
    input  logic                     flush,
    input  logic                     rob_full,
    input  logic                     rs_full,
    input  logic                     lsb_full,
    input  logic [ROB_WIDTH_BIT-1:0] rob_tail,
    output logic [4:0]               ask_reg_id1,
    output logic [4:0]               ask_reg_id2,
    input  logic [31:0]              REGF_ret_val_id1,
    input  logic [31:0]              REGF_ret_val_id2,
    input  logic                     REGF_dep_rs1,
    input  logic                     REGF_dep_rs2,
    input  logic [ROB_WIDTH_BIT-1:0] REGF_ret_ROB_id1,
    input  logic [ROB_WIDTH_BIT-1:0] REGF_ret_ROB_id2,
    output logic                     disp_valid,
    output logic [1:0]               disp_unit,
    output logic [4:0]               disp_op,
    output rob_type_t                disp_rob_type,
    output logic [4:0]               disp_rd,
    output logic [31:0]              disp_pc,
    output logic [31:0]              disp_imm,
    output logic [31:0]              disp_rs1_val,
    output logic [31:0]              disp_rs2_val,
    output logic                     disp_qi_valid,
    output logic                     disp_qj_valid,
    output logic [ROB_WIDTH_BIT-1:0] disp_qi,
    output logic [ROB_WIDTH_BIT-1:0] disp_qj,
    output logic [ROB_WIDTH_BIT-1:0] disp_rob_id,
    output logic                     disp_rob_ready,
    output logic [31:0]              disp_rob_value,
    output logic [31:0]              disp_jp_addr
);
    localparam int DEPTH = 2 ** IQ_DEPTH_BIT;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    typedef struct packed {
        logic                     valid;
        logic [1:0]               unit;
        logic [4:0]               op;
        rob_type_t                rob_type;
        logic [4:0]               rd;
        logic [31:0]              pc;
        logic [31:0]              imm;
        logic [31:0]              rs1_val;
        logic [31:0]              rs2_val;
        logic                     qi_valid;
        logic                     qj_valid;
        logic [ROB_WIDTH_BIT-1:0] qi;
        logic [ROB_WIDTH_BIT-1:0] qj;
        logic [ROB_WIDTH_BIT-1:0] rob_id;
        logic                     rob_ready;
        logic [31:0]              rob_value;
        logic [31:0]              jp_addr;
        logic                     clear;
        logic [31:0]              new_addr;
    } disp_t;

    entry_t [DEPTH-1:0]      mem_q, mem_d;
    logic [IQ_DEPTH_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [IQ_DEPTH_BIT:0]   count_q, count_d;
    disp_t                   disp_q, disp_d, bundle;

    entry_t      head;
    logic [31:0] hi;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_r, is_i, is_b, is_l, is_s, is_jal, is_jalr, is_lui, is_auipc;
    logic        to_rs, to_lsb, uses_rs1, uses_rs2, writes_rd, alt;
    logic        go, redirect, push;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign head     = mem_q[head_q];
    assign hi       = head.ins;
    assign opcode   = hi[6:0];
    assign funct3   = hi[14:12];
    assign is_r     = (opcode == OP_REG);
    assign is_i     = (opcode == OP_IMM);
    assign is_b     = (opcode == OP_BR);
    assign is_l     = (opcode == OP_LOAD);
    assign is_s     = (opcode == OP_STORE);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);

    assign to_rs     = is_r | is_i | is_b;
    assign to_lsb    = is_l | is_s;
    assign uses_rs1  = is_r | is_i | is_b | is_l | is_s | is_jalr;
    assign uses_rs2  = is_r | is_b | is_s;
    assign writes_rd = is_r | is_i | is_l | is_jal | is_jalr | is_lui | is_auipc;
    // funct7[5] selects SUB/SRA; for immediates only SRAI carries it.
    assign alt       = hi[30] & (is_r | (is_i & (funct3 == 3'b101)));

    assign imm_i = {{20{hi[31]}}, hi[31:20]};
    assign imm_s = {{20{hi[31]}}, hi[31:25], hi[11:7]};
    assign imm_b = {{19{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
    assign imm_u = {hi[31:12], 12'b0};
    assign imm_j = {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};

    assign iq_full  = (count_q == (IQ_DEPTH_BIT + 1)'(DEPTH));
    assign push     = ins_valid & ~iq_full;
    assign go       = (count_q != '0) & ~rob_full & ~(to_rs & rs_full)
                    & ~(to_lsb & lsb_full) & ~(is_jalr & REGF_dep_rs1);
    assign redirect = go & (is_jal | is_jalr);

    assign ask_reg_id1 = hi[19:15];
    assign ask_reg_id2 = hi[24:20];

    // Unrecognised opcodes fall through as ROB-only, ready entries so the queue never wedges.
    always_comb begin
        bundle           = '0;
        bundle.valid     = 1'b1;
        bundle.unit      = to_rs ? 2'd1 : (to_lsb ? 2'd2 : 2'd0);
        bundle.rob_type  = is_s ? TypeSt : (is_b ? TypeBr : TypeRd);
        bundle.rd        = writes_rd ? hi[11:7] : 5'd0;
        bundle.pc        = head.pc;
        bundle.rs1_val   = REGF_ret_val_id1;
        bundle.rs2_val   = REGF_ret_val_id2;
        bundle.qi_valid  = uses_rs1 & REGF_dep_rs1;
        bundle.qj_valid  = uses_rs2 & REGF_dep_rs2;
        bundle.qi        = REGF_ret_ROB_id1;
        bundle.qj        = REGF_ret_ROB_id2;
        bundle.rob_id    = rob_tail;
        bundle.rob_ready = ~(to_rs | to_lsb);
        bundle.new_addr  = disp_q.new_addr;
        if (is_b)
            bundle.op = {2'b10, funct3};
        else if (to_rs)
            bundle.op = {1'b0, alt, funct3};
        else if (to_lsb)
            bundle.op = {1'b0, ~opcode[5], funct3};
        if (is_i)
            bundle.imm = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'b0, hi[24:20]} : imm_i;
        else if (is_l || is_jalr)
            bundle.imm = imm_i;
        else if (is_s)
            bundle.imm = imm_s;
        else if (is_b)
            bundle.imm = imm_b;
        else if (is_lui || is_auipc)
            bundle.imm = imm_u;
        else if (is_jal)
            bundle.imm = imm_j;
        if (is_jal || is_jalr)
            bundle.rob_value = head.pc + 32'd4;
        else if (is_lui)
            bundle.rob_value = imm_u;
        else if (is_auipc)
            bundle.rob_value = head.pc + imm_u;
        if (is_b)
            bundle.jp_addr = head.pred ? head.pc + 32'd4 : head.pc + imm_b;
        bundle.clear = is_jal | is_jalr;
        if (is_jal)
            bundle.new_addr = head.pc + imm_j;
        else if (is_jalr)
            bundle.new_addr = (REGF_ret_val_id1 + imm_i) & ~32'd1;
    end

    always_comb begin
        mem_d        = mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        disp_d       = disp_q;
        disp_d.valid = 1'b0;
        disp_d.clear = 1'b0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (!rdy_in) begin
            disp_d = disp_q;
        end else begin
            if (redirect) begin
                // Younger entries are on the wrong path; same-cycle push is dropped too.
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    mem_d[tail_q] = '{ins: ins, pc: pc, pred: pred_jump};
                    tail_d        = tail_q + IQ_DEPTH_BIT'(1);
                end
                if (go)
                    head_d = head_q + IQ_DEPTH_BIT'(1);
                if (push && !go)
                    count_d = count_q + (IQ_DEPTH_BIT + 1)'(1);
                else if (!push && go)
                    count_d = count_q - (IQ_DEPTH_BIT + 1)'(1);
            end
            if (go)
                disp_d = bundle;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            disp_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            disp_q  <= disp_d;
        end
    end

    assign disp_valid        = disp_q.valid;
    assign disp_unit         = disp_q.unit;
    assign disp_op           = disp_q.op;
    assign disp_rob_type     = disp_q.rob_type;
    assign disp_rd           = disp_q.rd;
    assign disp_pc           = disp_q.pc;
    assign disp_imm          = disp_q.imm;
    assign disp_rs1_val      = disp_q.rs1_val;
    assign disp_rs2_val      = disp_q.rs2_val;
    assign disp_qi_valid     = disp_q.qi_valid;
    assign disp_qj_valid     = disp_q.qj_valid;
    assign disp_qi           = disp_q.qi;
    assign disp_qj           = disp_q.qj;
    assign disp_rob_id       = disp_q.rob_id;
    assign disp_rob_ready    = disp_q.rob_ready;
    assign disp_rob_value    = disp_q.rob_value;
    assign disp_jp_addr      = disp_q.jp_addr;
    assign IFetcher_clear    = disp_q.clear;
    assign IFetcher_new_addr = disp_q.new_addr;
endmodule

// File: tb/tb_issue_queue_decoder.sv
// Directed bench: stimulus pushes expected dispatch bundles into a scoreboard
// queue, a negedge monitor pops and compares whenever disp_valid is seen.
module tb_issue_queue_decoder;
    import issue_queue_decoder_pkg::*;

    localparam int RW = 5;
    localparam logic [31:0] ADDI  = 32'h00100093;  // addi x1,x0,1
    localparam logic [31:0] JAL   = 32'h020000EF;  // jal x1,+0x20
    localparam logic [31:0] JALR  = 32'h004102E7;  // jalr x5,4(x2)
    localparam logic [31:0] BEQ   = 32'hFE208CE3;  // beq x1,x2,-8
    localparam logic [31:0] SW    = 32'h00322423;  // sw x3,8(x4)
    localparam logic [31:0] LW    = 32'hFFC22303;  // lw x6,-4(x4)
    localparam logic [31:0] AUIPC = 32'h12345397;  // auipc x7,0x12345
    localparam logic [31:0] SRAI  = 32'h4030D413;  // srai x8,x1,3
    localparam logic [31:0] V1    = 32'h11111111;
    localparam logic [31:0] V2    = 32'h22222222;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, ins_valid, pred_jump, flush, rob_full, rs_full, lsb_full;
    logic REGF_dep_rs1, REGF_dep_rs2;
    logic [31:0] ins, pc, REGF_ret_val_id1, REGF_ret_val_id2;
    logic [RW-1:0] rob_tail, REGF_ret_ROB_id1, REGF_ret_ROB_id2;
    logic iq_full, IFetcher_clear, disp_valid, disp_qi_valid, disp_qj_valid, disp_rob_ready;
    logic [31:0] IFetcher_new_addr, disp_pc, disp_imm, disp_rs1_val, disp_rs2_val;
    logic [31:0] disp_rob_value, disp_jp_addr;
    logic [4:0] ask_reg_id1, ask_reg_id2, disp_op, disp_rd;
    logic [1:0] disp_unit;
    rob_type_t disp_rob_type;
    logic [RW-1:0] disp_qi, disp_qj, disp_rob_id;

    issue_queue_decoder #(.IQ_DEPTH_BIT(2), .ROB_WIDTH_BIT(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .ins_valid(ins_valid), .ins(ins), .pc(pc), .pred_jump(pred_jump),
        .iq_full(iq_full), .IFetcher_clear(IFetcher_clear), .IFetcher_new_addr(IFetcher_new_addr),
        .flush(flush), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_tail(rob_tail), .ask_reg_id1(ask_reg_id1), .ask_reg_id2(ask_reg_id2),
        .REGF_ret_val_id1(REGF_ret_val_id1), .REGF_ret_val_id2(REGF_ret_val_id2),
        .REGF_dep_rs1(REGF_dep_rs1), .REGF_dep_rs2(REGF_dep_rs2),
        .REGF_ret_ROB_id1(REGF_ret_ROB_id1), .REGF_ret_ROB_id2(REGF_ret_ROB_id2),
        .disp_valid(disp_valid), .disp_unit(disp_unit), .disp_op(disp_op),
        .disp_rob_type(disp_rob_type), .disp_rd(disp_rd), .disp_pc(disp_pc),
        .disp_imm(disp_imm), .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
        .disp_qi_valid(disp_qi_valid), .disp_qj_valid(disp_qj_valid),
        .disp_qi(disp_qi), .disp_qj(disp_qj), .disp_rob_id(disp_rob_id),
        .disp_rob_ready(disp_rob_ready), .disp_rob_value(disp_rob_value),
        .disp_jp_addr(disp_jp_addr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [1:0]    unit;
        logic [4:0]    op;
        logic [1:0]    rt;
        logic [4:0]    rd;
        logic [31:0]   pc, imm, v1, v2;
        logic          qiv, qjv;
        logic [RW-1:0] qi, qj, rid;
        logic          rdy;
        logic [31:0]   val, jp;
        logic          clr;
        logic [31:0]   na;
    } bundle_t;

    bundle_t exp_q[$];
    bundle_t mon_a, mon_e;
    int checks = 0;
    int errors = 0;

    function automatic bundle_t mk(input logic [1:0] unit, input logic [4:0] op,
                                   input rob_type_t rt, input logic [4:0] rd,
                                   input logic [31:0] p, input logic [31:0] imm,
                                   input logic [31:0] v1, input logic [31:0] v2,
                                   input logic qiv, input logic qjv,
                                   input logic [RW-1:0] qi, input logic [RW-1:0] qj,
                                   input logic [RW-1:0] rid, input logic rdy,
                                   input logic [31:0] val, input logic [31:0] jp,
                                   input logic clr, input logic [31:0] na);
        bundle_t b;
        b.unit = unit; b.op = op; b.rt = rt; b.rd = rd; b.pc = p; b.imm = imm;
        b.v1 = v1; b.v2 = v2; b.qiv = qiv; b.qjv = qjv; b.qi = qi; b.qj = qj;
        b.rid = rid; b.rdy = rdy; b.val = val; b.jp = jp; b.clr = clr; b.na = na;
        return b;
    endfunction

    function automatic bundle_t act();
        bundle_t b;
        b.unit = disp_unit; b.op = disp_op; b.rt = disp_rob_type; b.rd = disp_rd;
        b.pc = disp_pc; b.imm = disp_imm; b.v1 = disp_rs1_val; b.v2 = disp_rs2_val;
        b.qiv = disp_qi_valid; b.qjv = disp_qj_valid; b.qi = disp_qi; b.qj = disp_qj;
        b.rid = disp_rob_id; b.rdy = disp_rob_ready; b.val = disp_rob_value;
        b.jp = disp_jp_addr; b.clr = IFetcher_clear;
        b.na = IFetcher_clear ? IFetcher_new_addr : 32'h0;
        return b;
    endfunction

    always @(negedge clk_in) begin
        if (disp_valid) begin
            checks++;
            mon_a = act();
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dispatch got pc=%h expected none", disp_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL dispatch pc=%h got %h expected %h", mon_e.pc, mon_a, mon_e);
                end
            end
        end else if (IFetcher_clear) begin
            checks++;
            errors++;
            $display("FAIL stray_clear got 1 expected 0");
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, want);
        end
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] p, input logic pr);
        ins_valid = 1'b1;
        ins       = i;
        pc        = p;
        pred_jump = pr;
    endtask

    task automatic push1(input logic [31:0] i, input logic [31:0] p);
        offer(i, p, 1'b0);
        tick();
        ins_valid = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; ins_valid = 1'b0; ins = '0; pc = '0; pred_jump = 1'b0;
        flush = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail = '0;
        REGF_ret_val_id1 = V1; REGF_ret_val_id2 = V2;
        REGF_dep_rs1 = 1'b0; REGF_dep_rs2 = 1'b0;
        REGF_ret_ROB_id1 = 5'd3; REGF_ret_ROB_id2 = 5'd4;
        tick(); tick();
        chk("reset_disp_valid", disp_valid, 0);
        chk("reset_iq_full", iq_full, 0);
        chk("reset_clear", IFetcher_clear, 0);
        chk("reset_new_addr", IFetcher_new_addr, 0);
        chk("reset_bundle_zero", 32'(act() == '0), 1);
        rst_in = 1'b0;

        // fill with RS blocked, fifth push refused, then drain back-to-back
        rs_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            offer(ADDI, 32'(k * 4), 1'b0);
            tick();
            if (k == 2) chk("iq_full_at3", iq_full, 0);
            if (k == 3) chk("iq_full_at4", iq_full, 1);
        end
        ins_valid = 1'b0;
        chk("iq_full_held", iq_full, 1);
        chk("ask_rs1", ask_reg_id1, 0);
        chk("ask_rs2", ask_reg_id2, 1);
        rs_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rob_tail = 5'(10 + k);
            exp_q.push_back(mk(2'd1, 5'b00000, TypeRd, 5'd1, 32'(k * 4), 32'd1, V1, V2,
                               1'b0, 1'b0, 5'd3, 5'd4, 5'(10 + k), 1'b0, 0, 0, 1'b0, 0));
            tick();
            chk("drain_consecutive", disp_valid, 1);
        end
        tick();
        chk("fifth_refused", disp_valid, 0);

        // JAL redirect with two younger entries and a same-cycle push
        rob_full = 1'b1;
        push1(JAL, 32'h100); push1(ADDI, 32'h104); push1(ADDI, 32'h108);
        rob_full = 1'b0; rob_tail = 5'd20;
        offer(ADDI, 32'h200, 1'b0);
        exp_q.push_back(mk(2'd0, 5'd0, TypeRd, 5'd1, 32'h100, 32'h20, V1, V2, 1'b0, 1'b0,
                           5'd3, 5'd4, 5'd20, 1'b1, 32'h104, 0, 1'b1, 32'h120));
        tick();
        ins_valid = 1'b0;
        chk("jal_clear", IFetcher_clear, 1);
        tick();
        chk("clear_pulse", IFetcher_clear, 0);
        chk("jal_emptied_not_full", iq_full, 0);
        tick();
        push1(ADDI, 32'h300);
        exp_q.push_back(mk(2'd1, 5'd0, TypeRd, 5'd1, 32'h300, 32'd1, V1, V2, 1'b0, 1'b0,
                           5'd3, 5'd4, 5'd20, 1'b0, 0, 0, 1'b0, 0));
        tick();

        // JALR waits on rs1 dependency
        REGF_dep_rs1 = 1'b1; rob_tail = 5'd21;
        push1(JALR, 32'h500);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("jalr_wait", disp_valid, 0);
        end
        chk("jalr_ask_rs1", ask_reg_id1, 2);
        REGF_dep_rs1 = 1'b0; REGF_ret_val_id1 = 32'h2001;
        exp_q.push_back(mk(2'd0, 5'd0, TypeRd, 5'd5, 32'h500, 32'd4, 32'h2001, V2, 1'b0, 1'b0,
                           5'd3, 5'd4, 5'd21, 1'b1, 32'h504, 0, 1'b1, 32'h2004));
        tick();
        chk("jalr_dispatch", disp_valid, 1);
        REGF_ret_val_id1 = V1;

        // BEQ recovery address, both predictions, rs1 dependency qualified
        REGF_dep_rs1 = 1'b1; REGF_ret_ROB_id1 = 5'd9; REGF_ret_ROB_id2 = 5'd10; rob_tail = 5'd22;
        offer(BEQ, 32'h40, 1'b1);
        exp_q.push_back(mk(2'd1, 5'b10000, TypeBr, 5'd0, 32'h40, 32'hFFFFFFF8, V1, V2, 1'b1, 1'b0,
                           5'd9, 5'd10, 5'd22, 1'b0, 0, 32'h44, 1'b0, 0));
        tick();
        offer(BEQ, 32'h40, 1'b0);
        exp_q.push_back(mk(2'd1, 5'b10000, TypeBr, 5'd0, 32'h40, 32'hFFFFFFF8, V1, V2, 1'b1, 1'b0,
                           5'd9, 5'd10, 5'd22, 1'b0, 0, 32'h38, 1'b0, 0));
        tick();
        ins_valid = 1'b0;
        tick(); tick();
        REGF_dep_rs1 = 1'b0; REGF_ret_ROB_id1 = 5'd3;

        // SW with rs2 dependency behind lsb_full, then LW (rs2 dependency ignored)
        REGF_dep_rs2 = 1'b1; REGF_ret_ROB_id2 = 5'd7; lsb_full = 1'b1; rob_tail = 5'd23;
        push1(SW, 32'h600);
        tick(); chk("sw_blocked", disp_valid, 0);
        tick(); chk("sw_blocked", disp_valid, 0);
        lsb_full = 1'b0;
        exp_q.push_back(mk(2'd2, 5'b00010, TypeSt, 5'd0, 32'h600, 32'd8, V1, V2, 1'b0, 1'b1,
                           5'd3, 5'd7, 5'd23, 1'b0, 0, 0, 1'b0, 0));
        offer(LW, 32'h604, 1'b0);
        tick();
        ins_valid = 1'b0;
        chk("sw_dispatch", disp_valid, 1);
        lsb_full = 1'b1;
        tick(); chk("lw_blocked", disp_valid, 0);
        lsb_full = 1'b0;
        exp_q.push_back(mk(2'd2, 5'b01010, TypeRd, 5'd6, 32'h604, 32'hFFFFFFFC, V1, V2, 1'b0, 1'b0,
                           5'd3, 5'd7, 5'd23, 1'b0, 0, 0, 1'b0, 0));
        tick(); chk("lw_dispatch", disp_valid, 1);
        REGF_dep_rs2 = 1'b0; REGF_ret_ROB_id2 = 5'd4;

        // AUIPC known result and SRAI zero-extended shift amount
        rob_tail = 5'd24;
        offer(AUIPC, 32'h700, 1'b0);
        tick();
        offer(SRAI, 32'h704, 1'b0);
        exp_q.push_back(mk(2'd0, 5'd0, TypeRd, 5'd7, 32'h700, 32'h12345000, V1, V2, 1'b0, 1'b0,
                           5'd3, 5'd4, 5'd24, 1'b1, 32'h12345700, 0, 1'b0, 0));
        tick();
        ins_valid = 1'b0;
        exp_q.push_back(mk(2'd1, 5'b01101, TypeRd, 5'd8, 32'h704, 32'd3, V1, V2, 1'b0, 1'b0,
                           5'd3, 5'd4, 5'd24, 1'b0, 0, 0, 1'b0, 0));
        tick(); tick();

        // flush with a push on a 3-entry queue
        rs_full = 1'b1;
        push1(ADDI, 32'h800); push1(ADDI, 32'h804); push1(ADDI, 32'h808);
        offer(ADDI, 32'h900, 1'b0);
        flush = 1'b1; rs_full = 1'b0;
        tick();
        flush = 1'b0; ins_valid = 1'b0;
        chk("flush_no_disp", disp_valid, 0);
        tick(); tick();
        chk("flush_empty_no_disp", disp_valid, 0);
        chk("flush_not_full", iq_full, 0);
        rob_tail = 5'd25;
        push1(ADDI, 32'hA00);
        exp_q.push_back(mk(2'd1, 5'd0, TypeRd, 5'd1, 32'hA00, 32'd1, V1, V2, 1'b0, 1'b0,
                           5'd3, 5'd4, 5'd25, 1'b0, 0, 0, 1'b0, 0));
        tick();
        chk("post_flush_dispatch", disp_valid, 1);

        // reset mid-stream kills the pending JAL redirect and the queue
        push1(JAL, 32'hB00);
        offer(ADDI, 32'hB04, 1'b0);
        rst_in = 1'b1;
        tick();
        ins_valid = 1'b0;
        chk("midrst_disp_valid", disp_valid, 0);
        chk("midrst_clear", IFetcher_clear, 0);
        chk("midrst_new_addr", IFetcher_new_addr, 0);
        chk("midrst_bundle_zero", 32'(act() == '0), 1);
        rst_in = 1'b0;
        tick(); tick(); tick();
        chk("midrst_queue_empty", disp_valid, 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
